// File: rtl/line_pkg.sv
// line_pkg: shared types for the line command sequencer.
package line_pkg;
    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;
    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
        logic   color;
    } line_cmd_t;
    typedef enum logic [1:0] {IDLE, LOAD, DRAW} seq_state_t;
endpackage

// File: rtl/line_cmd_fifo.sv
// line_cmd_fifo: show-ahead command FIFO; full/empty use an extra pointer bit.
module line_cmd_fifo
    import line_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  line_cmd_t din,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output line_cmd_t head
);
    localparam int AW = $clog2(DEPTH);
    line_cmd_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/line_sequencer.sv
// line_sequencer: queues line commands and sequences the Bresenham drawer,
// turning its x/y stream into a qualified pixel write strobe.
module line_sequencer
    import line_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int WATCHDOG = 2048
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [10:0]  cmd_x0,
    input  logic [10:0]  cmd_y0,
    input  logic [10:0]  cmd_x1,
    input  logic [10:0]  cmd_y1,
    input  logic         cmd_color,
    output logic         drw_reset,
    output logic [10:0]  drw_x0,
    output logic [10:0]  drw_y0,
    output logic [10:0]  drw_x1,
    output logic [10:0]  drw_y1,
    input  logic [10:0]  drw_x,
    input  logic [10:0]  drw_y,
    input  logic         drw_done,
    output logic         pix_we,
    output logic [10:0]  pix_x,
    output logic [10:0]  pix_y,
    output logic         pix_color,
    output logic         line_done,
    output logic         busy,
    output logic         err
);
    localparam int CW = $clog2(WATCHDOG);
    seq_state_t state;
    logic [CW-1:0] cnt;
    logic full, empty, push, pop, finish;
    line_cmd_t head, cmd;

    assign cmd       = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, color: cmd_color};
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign finish    = state == DRAW && (drw_done || cnt == CW'(WATCHDOG - 1));
    assign pop       = !empty && (state == IDLE || finish);
    assign drw_reset = state != DRAW;
    // cycle 0 of DRAW shows stale x/y and the done cycle repeats the last pixel
    assign pix_we    = state == DRAW && cnt != '0 && !drw_done;
    assign pix_x     = drw_x;
    assign pix_y     = drw_y;
    assign busy      = state != IDLE || !empty;

    line_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (cmd),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            drw_x0    <= '0;
            drw_y0    <= '0;
            drw_x1    <= '0;
            drw_y1    <= '0;
            pix_color <= 1'b0;
            line_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            line_done <= finish;
            if (finish && !drw_done) err <= 1'b1;
            if (pop) {drw_x0, drw_y0, drw_x1, drw_y1, pix_color} <= head;
            cnt   <= (state == DRAW && cnt != '1) ? cnt + CW'(1) : '0;
            state <= pop ? LOAD : state == LOAD ? DRAW : finish ? IDLE : state;
        end
    end
endmodule

// File: tb/tb_line_sequencer.sv
// tb_line_sequencer: randomized bench with a behavioural drawer and a pixel scoreboard.
module tb_line_sequencer;
    import line_pkg::*;
    localparam int DEPTH = 4, WATCHDOG = 64;
    typedef logic [21:0] xy_t;
    typedef xy_t xy_q_t[$];
    typedef logic [22:0] pix_t;

    logic clk = 0, reset = 1, cmd_valid = 0, cmd_color = 0;
    logic [10:0] cmd_x0 = 0, cmd_y0 = 0, cmd_x1 = 0, cmd_y1 = 0;
    logic cmd_ready, drw_reset, pix_we, pix_color, line_done, busy, err;
    logic [10:0] drw_x0, drw_y0, drw_x1, drw_y1, pix_x, pix_y;
    logic [10:0] drw_x = 0, drw_y = 0;
    logic drw_done = 0;
    int checks = 0, passed = 0, lines = 0, pix_cnt = 0, stall_pix = 0, idx = -1;
    bit stall = 0;
    pix_t exp_q[$];
    xy_q_t pts;

    always #10 clk = ~clk;

    line_sequencer #(.DEPTH(DEPTH), .WATCHDOG(WATCHDOG)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
        .drw_reset(drw_reset), .drw_x0(drw_x0), .drw_y0(drw_y0), .drw_x1(drw_x1), .drw_y1(drw_y1),
        .drw_x(drw_x), .drw_y(drw_y), .drw_done(drw_done), .pix_we(pix_we), .pix_x(pix_x),
        .pix_y(pix_y), .pix_color(pix_color), .line_done(line_done), .busy(busy), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic xy_q_t bres(input int x0, input int y0, input int x1, input int y1);
        xy_q_t q;
        int dx, dy, sx, sy, e, e2, x, y;
        x = x0; y = y0;
        dx = x1 > x0 ? x1 - x0 : x0 - x1;
        dy = y1 > y0 ? y0 - y1 : y1 - y0;
        sx = x0 < x1 ? 1 : -1;
        sy = y0 < y1 ? 1 : -1;
        e = dx + dy;
        forever begin
            q.push_back({11'(x), 11'(y)});
            if (x == x1 && y == y1) break;
            e2 = 2 * e;
            if (e2 >= dy) begin e += dy; x += sx; end
            if (e2 <= dx) begin e += dx; y += sy; end
        end
        return q;
    endfunction

    // drawer stand-in: loads endpoints while held in reset, one pixel per cycle, then done
    always @(posedge clk) begin
        if (drw_reset) begin
            pts = bres(int'(drw_x0), int'(drw_y0), int'(drw_x1), int'(drw_y1));
            idx = -1;
            drw_done <= 1'b0;
        end else if (idx < pts.size() - 1) begin
            idx++;
            {drw_x, drw_y} <= pts[idx];
        end else if (!stall) drw_done <= 1'b1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (pix_we) begin
                pix_cnt++;
                if (stall) stall_pix++;
                else check("pix", {pix_x, pix_y, pix_color}, exp_q.size() != 0 ? exp_q.pop_front() : 23'h7fffff);
            end
            if (line_done) begin
                lines++;
                stall = 0;
            end
        end
    end

    task automatic push(input int x0, input int y0, input int x1, input int y1, input logic c,
                        input bit track, output bit waited);
        xy_q_t q;
        int t;
        cmd_x0 = 11'(x0); cmd_y0 = 11'(y0); cmd_x1 = 11'(x1); cmd_y1 = 11'(y1); cmd_color = c;
        cmd_valid = 1;
        waited = 0;
        for (t = 0; t < 3000 && !cmd_ready; t++) begin
            waited = 1;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            check("push_timeout", cmd_ready, 1);
            cmd_valid = 0;
            return;
        end
        @(posedge clk);
        if (track) begin
            q = bres(x0, y0, x1, y1);
            foreach (q[i]) exp_q.push_back({q[i], c});
        end
        #1 cmd_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        for (int t = 0; t < 5000 && busy; t++) @(posedge clk) #1;
        check({tag, "_idle"}, busy, 0);
        repeat (2) @(negedge clk);
        check({tag, "_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_pix(input string tag);
        for (int t = 0; t < 200 && !pix_we; t++) @(posedge clk) #1;
        check({tag, "_start"}, pix_we, 1);
    endtask

    initial begin
        bit w;
        int l0, p0, lat, b, gap;
        #(20 * 90000);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit w;
        int l0, p0, lat, b, gap, bx, by;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_drw_reset", drw_reset, 1);
        check("rst_pix_we", pix_we, 0);
        check("rst_err", err, 0);
        check("rst_line_done", line_done, 0);
        check("rst_drw_x1", drw_x1, 0);
        reset = 0;
        @(negedge clk);

        // single horizontal line: latency, busy span, pixel count
        l0 = lines; p0 = pix_cnt;
        push(0, 0, 9, 0, 1, 1, w);
        lat = -1; b = 0;
        for (int n = 0; n < 100 && busy; n++) begin
            if (pix_we && lat < 0) lat = n;
            b++;
            @(posedge clk) #1;
        end
        check("t1_latency", lat, 3);
        check("t1_busy_cycles", b, 14);
        repeat (2) @(negedge clk);
        check("t1_lines", lines - l0, 1);
        check("t1_pixels", pix_cnt - p0, 10);
        check("t1_left", exp_q.size(), 0);

        // back-to-back lines: no IDLE between them
        l0 = lines; p0 = pix_cnt;
        push(0, 0, 9, 4, 0, 1, w);
        push(0, 0, 4, 9, 1, 1, w);
        for (int t = 0; t < 200 && !line_done; t++) @(posedge clk) #1;
        gap = 0;
        for (int t = 0; t < 20 && !pix_we; t++) begin
            gap++;
            @(posedge clk) #1;
        end
        check("t2_gap", gap, 2);
        wait_idle("t2");
        check("t2_lines", lines - l0, 2);
        check("t2_pixels", pix_cnt - p0, 20);

        // back-pressure while the drawer is busy on a long line
        l0 = lines;
        push(0, 0, 40, 10, 1, 1, w);
        wait_pix("t3");
        for (int i = 0; i < 4; i++) push(100 + i, 50, 90 + 3 * i, 60 + i, 1'(i), 1, w);
        check("t3_full", cmd_ready, 0);
        push(7, 7, 12, 3, 1, 1, w);
        check("t3_blocked", w, 1);
        wait_idle("t3");
        check("t3_lines", lines - l0, 6);

        // single-point line
        p0 = pix_cnt;
        push(5, 5, 5, 5, 1, 1, w);
        wait_idle("t4");
        check("t4_pixels", pix_cnt - p0, 1);

        // random traffic
        l0 = lines;
        for (int i = 0; i < 20; i++) begin
            bx = $urandom_range(0, 1900);
            by = $urandom_range(0, 1900);
            push(bx + $urandom_range(0, 40), by + $urandom_range(0, 40),
                 bx + $urandom_range(0, 40), by + $urandom_range(0, 40), 1'($urandom_range(0, 1)), 1, w);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle("rnd");
        check("rnd_lines", lines - l0, 20);
        check("rnd_err", err, 0);

        // watchdog abort on a drawer that never finishes
        l0 = lines;
        stall = 1; stall_pix = 0;
        push(100, 100, 110, 100, 1, 0, w);
        push(3, 3, 6, 6, 0, 1, w);
        wait_idle("t6");
        check("t6_stall_pixels", stall_pix, 63);
        check("t6_lines", lines - l0, 2);
        check("t6_err", err, 1);
        repeat (10) @(negedge clk);
        check("t6_err_sticky", err, 1);

        // asynchronous reset in the middle of a line with commands queued
        push(0, 0, 40, 0, 1, 1, w);
        push(1, 1, 20, 20, 1, 1, w);
        push(2, 2, 30, 5, 1, 1, w);
        wait_pix("t5");
        @(posedge clk);
        #3 reset = 1;
        #1;
        exp_q.delete();
        check("t5_drw_reset", drw_reset, 1);
        check("t5_pix_we", pix_we, 0);
        check("t5_busy", busy, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        check("t5_err", err, 0);
        check("t5_pix_color", pix_color, 0);
        check("t5_drw_x1", drw_x1, 0);
        @(negedge clk);
        reset = 0;
        p0 = pix_cnt;
        repeat (60) @(negedge clk);
        check("t5_no_pix", pix_cnt - p0, 0);
        check("t5_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
